// File: rtl/mmio_oam_dma_m_pkg.sv
// Shared CPU-side definitions for the OAM DMA slice: state encoding and fixed addresses.
package cpu_defs;
  typedef enum logic [1:0] {DMA_IDLE, DMA_START, DMA_XFER} dma_state_e;

  localparam logic [15:0]  OAM_DMA_REG = 16'hFF46;
  localparam logic [15:0]  OAM_BASE    = 16'hFE00;
  localparam int unsigned  OAM_SIZE    = 160;
endpackage

// File: rtl/mmio_oam_dma_m_if.sv
// Bus bundle for the OAM DMA engine: MMIO slave side plus the MMU DMA request port.
interface mmio_oam_dma_m_if;
  logic [15:0] mmio_addr;
  logic        mmio_wr;
  logic        mmio_rd;
  logic [7:0]  mmio_wdata;
  logic [7:0]  mmio_rdata;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic        dma_wr;
  logic [7:0]  dma_wdata;
  logic [7:0]  dma_rdata;
  logic        dma_active;

  modport master (
    output mmio_addr, mmio_wr, mmio_rd, mmio_wdata, dma_rdata,
    input  mmio_rdata, dma_addr, dma_rd, dma_wr, dma_wdata, dma_active
  );

  modport slave (
    input  mmio_addr, mmio_wr, mmio_rd, mmio_wdata, dma_rdata,
    output mmio_rdata, dma_addr, dma_rd, dma_wr, dma_wdata, dma_active
  );
endinterface

// File: rtl/mmio_oam_dma_m_seq.sv
// OAM DMA sequencer: start delay, per-byte phase counter and byte index, emitting
// the read/capture/write strobes and a done pulse on the final write.
module oam_dma_seq_m
  import cpu_defs::*;
#(
  parameter int unsigned NUM_BYTES       = OAM_SIZE,
  parameter int unsigned CYCLES_PER_BYTE = 4,
  parameter int unsigned START_DELAY     = 4,
  parameter int unsigned RD_LATENCY      = 1
) (
  input  logic       clk_4mhz,
  input  logic       rst,
  input  logic       start,
  output logic       rd_pulse,
  output logic       cap_pulse,
  output logic       wr_pulse,
  output logic       done,
  output logic [7:0] idx
);
  localparam int unsigned PW = $clog2(CYCLES_PER_BYTE);
  localparam int unsigned DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  localparam logic [PW-1:0] PH_CAP   = PW'(RD_LATENCY);
  localparam logic [PW-1:0] PH_LAST  = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [DW-1:0] DLY_LAST = DW'(START_DELAY - 1);
  localparam logic [7:0]    IDX_LAST = 8'(NUM_BYTES - 1);

  dma_state_e    state_q, state_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [7:0]    idx_q, idx_d;

  always_ff @(posedge clk_4mhz) begin
    if (rst) begin
      state_q <= DMA_IDLE;
      dly_q   <= '0;
      phase_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    rd_pulse  = 1'b0;
    cap_pulse = 1'b0;
    wr_pulse  = 1'b0;
    done      = 1'b0;

    case (state_q)
      DMA_START: begin
        if (dly_q == DLY_LAST) begin
          state_d = DMA_XFER;
          phase_d = '0;
          idx_d   = '0;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      DMA_XFER: begin
        rd_pulse  = (phase_q == '0);
        cap_pulse = (phase_q == PH_CAP);
        wr_pulse  = (phase_q == PH_LAST);
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (idx_q == IDX_LAST) begin
            done    = 1'b1;
            state_d = DMA_IDLE;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: ;
    endcase

    // A register write restarts the copy after this cycle's strobes have been issued,
    // so a write landing on the final byte still completes that byte.
    if (start) begin
      state_d = DMA_START;
      dly_d   = '0;
      phase_d = '0;
      idx_d   = '0;
    end
  end

  assign idx = idx_q;
endmodule

// File: rtl/mmio_oam_dma_m.sv
// OAM DMA engine at FF46: copies 160 bytes from XX00..XX9F to OAM via the MMU DMA port.
// Optional build macro DMA_ECHO_REMAP_EN maps source pages E0..FF onto C0..DF.
module mmio_oam_dma_m
  import cpu_defs::*;
#(
  parameter int unsigned NUM_BYTES       = OAM_SIZE,
  parameter int unsigned CYCLES_PER_BYTE = 4,
  parameter int unsigned START_DELAY     = 4,
  parameter logic [15:0] REG_ADDR        = OAM_DMA_REG,
  parameter logic [15:0] DST_BASE        = OAM_BASE,
  parameter int unsigned RD_LATENCY      = 1
) (
  input  logic             clk_4mhz,
  input  logic             rst,
  mmio_oam_dma_m_if.slave  bus
);
  logic [7:0] src_hi_q, src_hi_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] byte_q, byte_d;
  logic       active_q, active_d;
  logic [7:0] src_eff;
  logic       reg_wr;
  logic       rd_pulse, cap_pulse, wr_pulse, done;
  logic [7:0] idx;

  assign reg_wr = bus.mmio_wr && (bus.mmio_addr == REG_ADDR);

`ifdef DMA_ECHO_REMAP_EN
  assign src_eff = (src_hi_q >= 8'hE0) ? (src_hi_q - 8'h20) : src_hi_q;
`else
  assign src_eff = src_hi_q;
`endif

  oam_dma_seq_m #(
    .NUM_BYTES       (NUM_BYTES),
    .CYCLES_PER_BYTE (CYCLES_PER_BYTE),
    .START_DELAY     (START_DELAY),
    .RD_LATENCY      (RD_LATENCY)
  ) u_seq (
    .clk_4mhz  (clk_4mhz),
    .rst       (rst),
    .start     (reg_wr),
    .rd_pulse  (rd_pulse),
    .cap_pulse (cap_pulse),
    .wr_pulse  (wr_pulse),
    .done      (done),
    .idx       (idx)
  );

  always_ff @(posedge clk_4mhz) begin
    if (rst) begin
      src_hi_q <= '0;
      rdata_q  <= '1;
      byte_q   <= '0;
      active_q <= 1'b0;
    end else begin
      src_hi_q <= src_hi_d;
      rdata_q  <= rdata_d;
      byte_q   <= byte_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    src_hi_d = reg_wr ? bus.mmio_wdata : src_hi_q;
    rdata_d  = rdata_q;
    if (bus.mmio_rd) begin
      rdata_d = (bus.mmio_addr == REG_ADDR) ? src_hi_q : 8'hFF;
    end
    byte_d   = cap_pulse ? bus.dma_rdata : byte_q;
    // A restart on the done cycle keeps the engine busy.
    active_d = reg_wr ? 1'b1 : (done ? 1'b0 : active_q);
  end

  always_comb begin
    bus.dma_rd    = rd_pulse;
    bus.dma_wr    = wr_pulse;
    bus.dma_addr  = '0;
    bus.dma_wdata = '0;
    if (rd_pulse) begin
      bus.dma_addr = {src_eff, idx};
    end else if (wr_pulse) begin
      bus.dma_addr  = DST_BASE + {8'h00, idx};
      bus.dma_wdata = byte_q;
    end
  end

  assign bus.mmio_rdata = rdata_q;
  assign bus.dma_active = active_q;
endmodule

// File: tb/tb_mmio_oam_dma_m.sv
// Bench for mmio_oam_dma_m: per-cycle comparison of the DMA bus against a timeline model
// of the copy, plus OAM content and FF46 readback checks.
module tb_mmio_oam_dma_m;
  localparam int NB  = 160;
  localparam int CPB = 4;
  localparam int SD  = 4;
  localparam int TOTAL = SD + NB * CPB;

  logic clk_4mhz = 1'b0;
  logic rst = 1'b1;
  always #5 clk_4mhz = ~clk_4mhz;

  mmio_oam_dma_m_if bus();

  mmio_oam_dma_m dut (
    .clk_4mhz (clk_4mhz),
    .rst      (rst),
    .bus      (bus)
  );

  logic [7:0] mem [0:65535];
  logic [7:0] oam [0:159];
  int cyc = 0;
  int ts = -1;
  logic [7:0] src = 8'h00;
  logic [7:0] reg_val = 8'h00;
  logic chk_en = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  logic [26:0] mon_e, mon_o;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] srcx(input logic [7:0] s);
`ifdef DMA_ECHO_REMAP_EN
    if (s >= 8'hE0) return s - 8'h20;
`endif
    return s;
  endfunction

  // Expected {active, rd, wr, addr, wdata} in cycle n, derived from the last FF46 write.
  function automatic logic [26:0] exp_vec(input int n);
    logic act, r, w;
    logic [15:0] a;
    logic [7:0] d;
    int k, i;
    act = 1'b0; r = 1'b0; w = 1'b0; a = '0; d = '0;
    if (ts >= 0) begin
      act = (n - ts >= 1) && (n - ts <= TOTAL);
      k = n - ts - SD - 1;
      if (k >= 0 && k < NB * CPB) begin
        i = k / CPB;
        if (k % CPB == 0) begin
          r = 1'b1;
          a = {srcx(src), 8'(i)};
        end else if (k % CPB == CPB - 1) begin
          w = 1'b1;
          a = 16'hFE00 + 16'(i);
          d = mem[{srcx(src), 8'(i)}];
        end
      end
    end
    return {act, r, w, a, d};
  endfunction

  always @(posedge clk_4mhz) cyc <= cyc + 1;

  // MMU model: one-cycle read latency, OAM captures writes.
  always @(posedge clk_4mhz) begin
    if (bus.dma_rd) bus.dma_rdata <= mem[bus.dma_addr];
    if (bus.dma_wr && bus.dma_addr[15:8] == 8'hFE && bus.dma_addr[7:0] < 8'd160)
      oam[bus.dma_addr[7:0]] <= bus.dma_wdata;
  end

  always begin
    @(posedge clk_4mhz);
    #1;
    if (chk_en) begin
      mon_e = exp_vec(cyc);
      mon_o = {bus.dma_active, bus.dma_rd, bus.dma_wr, bus.dma_addr,
               mon_e[24] ? bus.dma_wdata : 8'h00};
      chk("bus", 32'(mon_o), 32'(mon_e));
    end
  end

  task automatic wr_reg(input logic [15:0] a, input logic [7:0] v);
    bus.mmio_addr  = a;
    bus.mmio_wdata = v;
    bus.mmio_wr    = 1'b1;
    if (a == 16'hFF46) begin
      ts = cyc;
      src = v;
      reg_val = v;
    end
    @(negedge clk_4mhz);
    bus.mmio_wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [15:0] a, input string tag);
    logic [7:0] e;
    e = (a == 16'hFF46) ? reg_val : 8'hFF;
    bus.mmio_addr = a;
    bus.mmio_rd   = 1'b1;
    @(negedge clk_4mhz);
    bus.mmio_rd = 1'b0;
    chk(tag, 32'(bus.mmio_rdata), 32'(e));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ts = -1;
    reg_val = 8'h00;
    @(negedge clk_4mhz);
    rst = 1'b0;
  endtask

  task automatic check_oam(input string tag);
    for (int i = 0; i < NB; i++)
      chk(tag, 32'(oam[i]), 32'(mem[{srcx(src), 8'(i)}]));
  endtask

  function automatic logic [7:0] rnd_src();
    logic [7:0] s;
    do s = 8'($urandom_range(0, 255)); while (s == 8'hFE);
    return s;
  endfunction

  initial begin
    logic [15:0] ra;
    int len, r;
    bus.mmio_addr = '0; bus.mmio_wr = 1'b0; bus.mmio_rd = 1'b0;
    bus.mmio_wdata = '0; bus.dma_rdata = '0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < NB; i++) mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < NB; i++) oam[i] = 8'h00;

    repeat (3) @(negedge clk_4mhz);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_rdata", 32'(bus.mmio_rdata), 32'hFF);

    rd_reg(16'hFF46, "rst_ff46");
    rd_reg(16'hFF40, "other_reg");

    // Basic copy from C1xx
    wr_reg(16'hFF46, 8'hC1);
    rd_reg(16'hFF46, "rb_c1");
    repeat (TOTAL + 4) @(negedge clk_4mhz);
    for (int i = 0; i < NB; i++) chk("oam_c1", 32'(oam[i]), 32'(8'(i) ^ 8'h5A));

    // Restart mid-copy
    wr_reg(16'hFF46, 8'hC0);
    repeat (199) @(negedge clk_4mhz);
    wr_reg(16'hFF46, 8'hD0);
    repeat (TOTAL + 4) @(negedge clk_4mhz);
    check_oam("oam_d0");

    // Reset mid-copy, then a full copy
    wr_reg(16'hFF46, 8'h80);
    repeat (298) @(negedge clk_4mhz);
    do_reset();
    repeat (20) @(negedge clk_4mhz);
    rd_reg(16'hFF46, "rb_after_rst");
    wr_reg(16'hFF46, 8'h45);
    repeat (TOTAL + 4) @(negedge clk_4mhz);
    check_oam("oam_45");

    // Echo page source
    wr_reg(16'hFF46, 8'hE3);
    repeat (TOTAL + 4) @(negedge clk_4mhz);
    rd_reg(16'hFF46, "rb_e3");
    check_oam("oam_e3");

    // Register write coincident with the final OAM write
    wr_reg(16'hFF46, 8'h12);
    repeat (TOTAL - 1) @(negedge clk_4mhz);
    wr_reg(16'hFF46, 8'hC1);
    repeat (TOTAL + 4) @(negedge clk_4mhz);
    for (int i = 0; i < NB; i++) chk("oam_back2back", 32'(oam[i]), 32'(8'(i) ^ 8'h5A));

    // Randomized restarts, resets, reads and stray writes
    for (int it = 0; it < 14; it++) begin
      wr_reg(16'hFF46, rnd_src());
      len = $urandom_range(1, TOTAL + 60);
      for (int j = 0; j < len; j++) begin
        r = $urandom_range(0, 999);
        if (r < 15) begin
          rd_reg(16'hFF46, "rnd_rb");
        end else if (r < 25) begin
          ra = 16'($urandom);
          if (ra == 16'hFF46) ra = 16'hFF47;
          rd_reg(ra, "rnd_rd_other");
        end else if (r < 35) begin
          ra = 16'($urandom);
          if (ra == 16'hFF46) ra = 16'hFF45;
          wr_reg(ra, 8'($urandom));
        end else if (r < 37) begin
          do_reset();
        end else begin
          @(negedge clk_4mhz);
        end
      end
    end

    wr_reg(16'hFF46, rnd_src());
    repeat (TOTAL + 4) @(negedge clk_4mhz);
    check_oam("oam_final");
    rd_reg(16'hFF46, "rb_final");

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
